// File: rtl/md_sched.sv
// md_sched: sequences the iterative HI/LO multiply/divide unit and raises the ID-stage stall
// while an operation is in flight.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2(DIV_CYCLES) + 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic        launch, done, sgn;
    logic [63:0] prod;
    logic [31:0] dvd, dvs, quo_m, rem_m, quo, rem;

    assign launch   = (state == IDLE) & start & (md_op <= 3'd3);
    assign done     = (state == RUN) & (cnt == '0);
    assign busy     = (state == RUN);
    assign stall_md = md_use_D & (busy | (start & (md_op <= 3'd3)));
    assign sgn      = ~op_q[0];

    always_comb begin
        state_nx = state;
        if (launch) state_nx = RUN;
        else if (done) state_nx = IDLE;
    end

    // Sign-extended 64-bit product; divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        prod  = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};
        dvd   = (sgn && a_q[31]) ? -a_q : a_q;
        dvs   = (sgn && b_q[31]) ? -b_q : b_q;
        quo_m = dvd / dvs;
        rem_m = dvd % dvs;
        quo   = (sgn && (a_q[31] ^ b_q[31])) ? -quo_m : quo_m;
        rem   = (sgn && a_q[31]) ? -rem_m : rem_m;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= md_op[1:0];
                cnt  <= md_op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            end else if (busy && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state == IDLE && start && md_op == 3'd4) HI <= A;
            if (state == IDLE && start && md_op == 3'd5) LO <= A;
            if (done && !op_q[1]) {HI, LO} <= prod;
            if (done && op_q[1] && b_q != '0) begin
                HI <= rem;
                LO <= quo;
            end
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed vectors for md_sched with hand-computed HI/LO, busy and stall values.
module tb_md_sched;
    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [2:0]  md_op = 0;
    logic [31:0] A = 0;
    logic [31:0] B = 0;
    logic        md_use_D = 0;
    logic        busy, stall_md;
    logic [31:0] HI, LO;
    int vectors = 0;
    int miscompares = 0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
        .md_use_D(md_use_D), .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op;
        A = a;
        B = b;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        reset = 0;
        tick();
        vectors++;
        if (HI !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", HI); end
        vectors++;
        if (LO !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", LO); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (stall_md !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_md); end
    endtask

    task automatic test_mult();
        launch(3'd0, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL mult_busy[%0d]: got %b want 1", i, busy); end
            vectors++;
            if (HI !== 32'h0) begin miscompares++; $display("FAIL mult_early_hi[%0d]: got %h want 0", i, HI); end
            tick();
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mult_busy_end: got %b want 0", busy); end
        vectors++;
        if (HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        vectors++;
        if (LO !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
        launch(3'd1, 32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (HI !== 32'h0000_0002) begin miscompares++; $display("FAIL multu_hi: got %h want 00000002", HI); end
        vectors++;
        if (LO !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL multu_lo: got %h want fffffffa", LO); end
    endtask

    task automatic test_div();
        launch(3'd2, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL div_busy[%0d]: got %b want 1", i, busy); end
            tick();
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL div_busy_end: got %b want 0", busy); end
        vectors++;
        if (LO !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        vectors++;
        if (HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_hi: got %h want ffffffff", HI); end
        launch(3'd3, 32'd7, 32'd0);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL divz_busy[%0d]: got %b want 1", i, busy); end
            tick();
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL divz_busy_end: got %b want 0", busy); end
        vectors++;
        if (LO !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL divz_lo: got %h want fffffffd", LO); end
        vectors++;
        if (HI !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divz_hi: got %h want ffffffff", HI); end
        launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (LO !== 32'h8000_0000) begin miscompares++; $display("FAIL divovf_lo: got %h want 80000000", LO); end
        vectors++;
        if (HI !== 32'h0) begin miscompares++; $display("FAIL divovf_hi: got %h want 0", HI); end
        launch(3'd3, 32'hFFFF_FFFF, 32'd16);
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (LO !== 32'h0FFF_FFFF) begin miscompares++; $display("FAIL divu_lo: got %h want 0fffffff", LO); end
        vectors++;
        if (HI !== 32'h0000_000F) begin miscompares++; $display("FAIL divu_hi: got %h want 0000000f", HI); end
    endtask

    task automatic test_stall();
        md_use_D = 1;
        md_op = 3'd0;
        A = 32'h0001_0000;
        B = 32'h0001_0000;
        start = 1;
        #1;
        vectors++;
        if (stall_md !== 1'b1) begin miscompares++; $display("FAIL stall_launch: got %b want 1", stall_md); end
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (stall_md !== 1'b1) begin miscompares++; $display("FAIL stall_busy[%0d]: got %b want 1", i, stall_md); end
            tick();
        end
        vectors++;
        if (stall_md !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %b want 0", stall_md); end
        vectors++;
        if (HI !== 32'h0000_0001) begin miscompares++; $display("FAIL stall_mfhi: got %h want 00000001", HI); end
        vectors++;
        if (LO !== 32'h0) begin miscompares++; $display("FAIL stall_lo: got %h want 0", LO); end
        md_use_D = 0;
    endtask

    task automatic test_mt();
        launch(3'd5, 32'h1234_5678, 32'd0);
        vectors++;
        if (LO !== 32'h1234_5678) begin miscompares++; $display("FAIL mtlo_lo: got %h want 12345678", LO); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy: got %b want 0", busy); end
        vectors++;
        if (HI !== 32'h0000_0001) begin miscompares++; $display("FAIL mtlo_hi: got %h want 00000001", HI); end
        launch(3'd4, 32'hCAFE_BABE, 32'd0);
        vectors++;
        if (HI !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL mthi_hi: got %h want cafebabe", HI); end
        vectors++;
        if (LO !== 32'h1234_5678) begin miscompares++; $display("FAIL mthi_lo: got %h want 12345678", LO); end
        launch(3'd6, 32'hDEAD_BEEF, 32'd1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rsvd_busy: got %b want 0", busy); end
        vectors++;
        if (HI !== 32'hCAFE_BABE || LO !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL rsvd_hilo: got %h/%h want cafebabe/12345678", HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        launch(3'd2, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy[%0d]: got %b want 1", i, busy); end
            if (i == 3) begin
                md_op = 3'd0;
                A = 32'd5;
                B = 32'd5;
                start = 1;
            end
            tick();
            start = 0;
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
        vectors++;
        if (LO !== 32'd14) begin miscompares++; $display("FAIL b2b_lo: got %h want 0000000e", LO); end
        vectors++;
        if (HI !== 32'd2) begin miscompares++; $display("FAIL b2b_hi: got %h want 00000002", HI); end
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            miscompares++;
            $display("FAIL b2b_no_mult: got %h/%h want 00000002/0000000e", HI, LO);
        end
    endtask

    task automatic test_reset_mid();
        launch(3'd2, 32'd50, 32'd3);
        for (int i = 0; i < 3; i++) tick();
        #2;
        reset = 1;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
        vectors++;
        if (HI !== 32'h0 || LO !== 32'h0) begin
            miscompares++;
            $display("FAIL rmid_hilo: got %h/%h want 0/0", HI, LO);
        end
        tick();
        #2;
        reset = 0;
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
        vectors++;
        if (HI !== 32'h0 || LO !== 32'h0) begin
            miscompares++;
            $display("FAIL rmid_no_commit: got %h/%h want 0/0", HI, LO);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mt();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
